alu_seq_frontend: RTL and testbench

- Upstream request sequencer for the 8-bit serial ALU.
- Accepts one parallel operation request per valid/ready handshake and pulses the ALU start signal.
- Streams the operand bytes onto the ALU input bus in the fixed load order, waits for the ALU end flag, then captures the two result bytes from the ALU output bus.
- Returns a 16-bit result with its own valid/ready handshake; also screens out divide-by-zero and guards against a hung ALU with a watchdog.

---
 rtl/alu_seq_frontend.sv | 153 +++++++++++++++
 tb/tb_alu_seq_frontend.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_frontend.sv
// Request sequencer in front of the 8-bit serial ALU: accepts one operation,
// streams its operand bytes, waits for the ALU end flag, returns a 16-bit result.
module alu_seq_frontend #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_x,
  input  logic [7:0]  req_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        alu_begin,
  output logic [1:0]  alu_op_code,
  output logic [7:0]  alu_inbus,
  input  logic [7:0]  alu_outbus,
  input  logic        alu_end,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // rsp_data/rsp_err stay stable while rsp_valid is high and rsp_ready is low.
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_LOAD, S_WAIT, S_CAPT_LO, S_RESP
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_ONE  = CNT_W'(1);

  state_t            state;
  logic [1:0]        op_q;
  logic [15:0]       x_q;
  logic [7:0]        y_q;
  logic [1:0]        idx;
  logic [CNT_W-1:0]  wd;
  logic [7:0]        hi_q;
  logic [1:0]        last_idx;

  assign state_dbg = state;
  assign last_idx  = (op_q == 2'b11) ? 2'd2 : 2'd1;

  // Load order: divide sends the 16-bit dividend high byte first, others send X[7:0]
  function automatic logic [7:0] byte_at(input logic [1:0] op, input logic [15:0] x,
                                         input logic [7:0] y, input logic [1:0] i);
    if (op == 2'b11) begin
      case (i)
        2'd0:    return x[15:8];
        2'd1:    return x[7:0];
        default: return y;
      endcase
    end
    return (i == 2'd0) ? x[7:0] : y;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      op_q        <= 2'b00;
      x_q         <= 16'h0000;
      y_q         <= 8'h00;
      idx         <= 2'd0;
      wd          <= '0;
      hi_q        <= 8'h00;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= 16'h0000;
      rsp_err     <= 1'b0;
      alu_begin   <= 1'b0;
      alu_op_code <= 2'b00;
      alu_inbus   <= 8'h00;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            x_q       <= req_x;
            y_q       <= req_y;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_op == 2'b11 && req_y == 8'h00) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= 16'hFFFF;
              rsp_err   <= 1'b1;
            end else begin
              state       <= S_START;
              alu_begin   <= 1'b1;
              alu_op_code <= req_op;
              idx         <= 2'd0;
            end
          end
        end
        S_START: begin
          alu_begin <= 1'b0;
          alu_inbus <= byte_at(op_q, x_q, y_q, 2'd0);
          idx       <= 2'd0;
          state     <= S_LOAD;
        end
        S_LOAD: begin
          if (idx == last_idx) begin
            alu_inbus <= 8'h00;
            wd        <= '0;
            state     <= S_WAIT;
          end else begin
            idx       <= idx + 2'd1;
            alu_inbus <= byte_at(op_q, x_q, y_q, idx + 2'd1);
          end
        end
        S_WAIT: begin
          // alu_end wins over the watchdog on the final cycle
          if (alu_end) begin
            hi_q  <= alu_outbus;
            state <= S_CAPT_LO;
          end else if (wd == WD_LAST) begin
            state       <= S_RESP;
            rsp_valid   <= 1'b1;
            rsp_data    <= 16'h0000;
            rsp_err     <= 1'b1;
            alu_op_code <= 2'b00;
          end else begin
            wd <= wd + WD_ONE;
          end
        end
        S_CAPT_LO: begin
          state       <= S_RESP;
          rsp_valid   <= 1'b1;
          rsp_err     <= 1'b0;
          alu_op_code <= 2'b00;
          rsp_data    <= op_q[1] ? {hi_q, alu_outbus} : {{8{hi_q[7]}}, hi_q};
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= 16'h0000;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_frontend.sv
// Directed bench for alu_seq_frontend: a small ALU model answers each request
// with hand-computed result bytes; each scenario task checks its own results.
module tb_alu_seq_frontend;

  localparam int TIMEOUT_CYCLES = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_x;
  logic [7:0]  req_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        alu_begin;
  logic [1:0]  alu_op_code;
  logic [7:0]  alu_inbus;
  logic [7:0]  alu_outbus;
  logic        alu_end;
  logic        busy;
  logic [2:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  int          r_lat, r_begin;
  logic [31:0] r_bytes;
  logic [15:0] r_data;
  logic        r_err, r_stable, r_after_ready, r_after_valid;
  logic [1:0]  r_opc;

  alu_seq_frontend #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(7)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_begin(alu_begin), .alu_op_code(alu_op_code), .alu_inbus(alu_inbus),
    .alu_outbus(alu_outbus), .alu_end(alu_end), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver plus ALU model. Cycle 0 is the accept edge; cyc counts cycles after it.
  // end_delay is the WAIT-cycle index on which alu_end pulses (<0: never).
  task automatic run_txn(input logic [1:0] op, input logic [15:0] x, input logic [7:0] y,
                         input logic [7:0] hi, input logic [7:0] lo,
                         input int end_delay, input int hold);
    int nb, end_cyc, cyc;
    nb = (op == 2'b11) ? 3 : 2;
    end_cyc = (end_delay < 0) ? -10 : 2 + nb + end_delay;
    r_lat = -1; r_begin = 0; r_bytes = '0; r_data = '0; r_err = 1'b0;
    r_stable = 1'b1; r_after_ready = 1'b0; r_after_valid = 1'b1; r_opc = 2'b00;
    rsp_ready = 1'b0;
    req_op = op; req_x = x; req_y = y; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    cyc = 1;
    while (cyc < 300 && r_lat < 0) begin
      if (alu_begin) r_begin++;
      if (cyc == 1) r_opc = alu_op_code;
      if (cyc >= 2 && cyc <= 5) r_bytes[8*(cyc-2) +: 8] = alu_inbus;
      if (rsp_valid) begin
        r_lat  = cyc;
        r_data = rsp_data;
        r_err  = rsp_err;
      end else begin
        alu_end    = (cyc == end_cyc);
        alu_outbus = (cyc == end_cyc) ? hi : (cyc == end_cyc + 1) ? lo : 8'h00;
        step();
        cyc++;
      end
    end
    alu_end = 1'b0;
    alu_outbus = 8'h00;
    if (r_lat >= 0) begin
      for (int i = 0; i <= hold; i++) begin
        if (rsp_data !== r_data || rsp_err !== r_err || req_ready !== 1'b0 || rsp_valid !== 1'b1)
          r_stable = 1'b0;
        if (i < hold) step();
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      r_after_valid = rsp_valid;
      r_after_ready = req_ready;
    end
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    checks++; if (alu_begin !== 1'b0) begin failures++; $display("FAIL reset_alu_begin: got %b want 0", alu_begin); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (rsp_data !== 16'h0000) begin failures++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
    checks++; if (alu_inbus !== 8'h00) begin failures++; $display("FAIL reset_alu_inbus: got %h want 00", alu_inbus); end
    checks++; if (alu_op_code !== 2'b00) begin failures++; $display("FAIL reset_alu_op_code: got %b want 00", alu_op_code); end
  endtask

  task automatic test_add();
    run_txn(2'b00, 16'h0025, 8'h13, 8'h38, 8'h00, 0, 0);
    checks++; if (r_begin !== 1) begin failures++; $display("FAIL add_begin_count: got %0d want 1", r_begin); end
    checks++; if (r_opc !== 2'b00) begin failures++; $display("FAIL add_op_code: got %b want 00", r_opc); end
    checks++; if (r_bytes[23:0] !== 24'h001325) begin failures++; $display("FAIL add_bytes: got %h want 001325", r_bytes[23:0]); end
    checks++; if (r_lat !== 6) begin failures++; $display("FAIL add_latency: got %0d want 6", r_lat); end
    checks++; if ({r_data, r_err} !== {16'h0038, 1'b0}) begin failures++; $display("FAIL add_result: got %h/%b want 0038/0", r_data, r_err); end
    checks++; if ({r_after_valid, r_after_ready} !== 2'b01) begin failures++; $display("FAIL add_return_idle: got v=%b r=%b want v=0 r=1", r_after_valid, r_after_ready); end
  endtask

  task automatic test_sub();
    run_txn(2'b01, 16'h0010, 8'h20, 8'hF0, 8'h5A, 3, 0);
    checks++; if (r_bytes[23:0] !== 24'h002010) begin failures++; $display("FAIL sub_bytes: got %h want 002010", r_bytes[23:0]); end
    checks++; if (r_lat !== 9) begin failures++; $display("FAIL sub_latency: got %0d want 9", r_lat); end
    checks++; if ({r_data, r_err} !== {16'hFFF0, 1'b0}) begin failures++; $display("FAIL sub_result: got %h/%b want FFF0/0", r_data, r_err); end
  endtask

  task automatic test_mul();
    run_txn(2'b10, 16'h00FD, 8'h05, 8'hFF, 8'hF1, 2, 0);
    checks++; if (r_bytes[23:0] !== 24'h0005FD) begin failures++; $display("FAIL mul_bytes: got %h want 0005FD", r_bytes[23:0]); end
    checks++; if (r_lat !== 8) begin failures++; $display("FAIL mul_latency: got %0d want 8", r_lat); end
    checks++; if ({r_data, r_err} !== {16'hFFF1, 1'b0}) begin failures++; $display("FAIL mul_result: got %h/%b want FFF1/0", r_data, r_err); end
  endtask

  task automatic test_div();
    run_txn(2'b11, 16'h0064, 8'h07, 8'h02, 8'h0E, 1, 0);
    checks++; if (r_opc !== 2'b11) begin failures++; $display("FAIL div_op_code: got %b want 11", r_opc); end
    checks++; if (r_bytes !== 32'h00076400) begin failures++; $display("FAIL div_bytes: got %h want 00076400", r_bytes); end
    checks++; if (r_lat !== 8) begin failures++; $display("FAIL div_latency: got %0d want 8", r_lat); end
    checks++; if ({r_data, r_err} !== {16'h020E, 1'b0}) begin failures++; $display("FAIL div_result: got %h/%b want 020E/0", r_data, r_err); end
  endtask

  task automatic test_div_by_zero();
    run_txn(2'b11, 16'h1234, 8'h00, 8'h00, 8'h00, 0, 0);
    checks++; if (r_begin !== 0) begin failures++; $display("FAIL dbz_begin_count: got %0d want 0", r_begin); end
    checks++; if (r_lat !== 1) begin failures++; $display("FAIL dbz_latency: got %0d want 1", r_lat); end
    checks++; if ({r_data, r_err} !== {16'hFFFF, 1'b1}) begin failures++; $display("FAIL dbz_result: got %h/%b want FFFF/1", r_data, r_err); end
    checks++; if (r_after_ready !== 1'b1) begin failures++; $display("FAIL dbz_return_idle: got %b want 1", r_after_ready); end
  endtask

  task automatic test_timeout();
    // last byte in cycle 3, then TIMEOUT_CYCLES WAIT cycles, response next
    run_txn(2'b00, 16'h0001, 8'h01, 8'h00, 8'h00, -1, 0);
    checks++; if (r_lat !== 4 + TIMEOUT_CYCLES) begin failures++; $display("FAIL timeout_latency: got %0d want %0d", r_lat, 4 + TIMEOUT_CYCLES); end
    checks++; if ({r_data, r_err} !== {16'h0000, 1'b1}) begin failures++; $display("FAIL timeout_result: got %h/%b want 0000/1", r_data, r_err); end
    checks++; if (r_begin !== 1) begin failures++; $display("FAIL timeout_begin_count: got %0d want 1", r_begin); end
  endtask

  task automatic test_end_priority();
    run_txn(2'b10, 16'h0003, 8'h04, 8'h00, 8'h0C, TIMEOUT_CYCLES - 1, 0);
    checks++; if (r_lat !== 6 + TIMEOUT_CYCLES - 1) begin failures++; $display("FAIL endprio_latency: got %0d want %0d", r_lat, 5 + TIMEOUT_CYCLES); end
    checks++; if ({r_data, r_err} !== {16'h000C, 1'b0}) begin failures++; $display("FAIL endprio_result: got %h/%b want 000C/0", r_data, r_err); end
  endtask

  task automatic test_backpressure();
    run_txn(2'b00, 16'h007F, 8'h01, 8'h80, 8'h00, 0, 10);
    checks++; if ({r_data, r_err} !== {16'hFF80, 1'b0}) begin failures++; $display("FAIL bp_result: got %h/%b want FF80/0", r_data, r_err); end
    checks++; if (r_stable !== 1'b1) begin failures++; $display("FAIL bp_hold_stable: got %b want 1", r_stable); end
    checks++; if ({r_after_valid, r_after_ready} !== 2'b01) begin failures++; $display("FAIL bp_return_idle: got v=%b r=%b want v=0 r=1", r_after_valid, r_after_ready); end
  endtask

  task automatic test_reset_mid_load();
    logic quiet;
    req_op = 2'b11; req_x = 16'hABCD; req_y = 8'h03; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    checks++; if (alu_inbus !== 8'hAB) begin failures++; $display("FAIL rst_load_byte0: got %h want AB", alu_inbus); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({req_ready, busy, rsp_valid, rsp_err, alu_begin, alu_op_code, alu_inbus, rsp_data} !== {1'b1, 4'b0000, 2'b00, 8'h00, 16'h0000}) begin
      failures++;
      $display("FAIL rst_async_values: got rr=%b busy=%b rv=%b err=%b beg=%b op=%b in=%h data=%h want rr=1 others 0",
               req_ready, busy, rsp_valid, rsp_err, alu_begin, alu_op_code, alu_inbus, rsp_data);
    end
    step(); step();
    #2 reset = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (alu_begin !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin failures++; $display("FAIL rst_request_dropped: got %b want 1", quiet); end
    run_txn(2'b00, 16'h0041, 8'h01, 8'h42, 8'h00, 1, 0);
    checks++; if ({r_data, r_err} !== {16'h0042, 1'b0}) begin failures++; $display("FAIL rst_recover_result: got %h/%b want 0042/0", r_data, r_err); end
  endtask

  task automatic test_stray_end();
    logic idle_ok;
    idle_ok = 1'b1;
    alu_end = 1'b1;
    alu_outbus = 8'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) idle_ok = 1'b0;
    end
    alu_end = 1'b0;
    alu_outbus = 8'h00;
    checks++; if (idle_ok !== 1'b1) begin failures++; $display("FAIL stray_end_idle: got %b want 1", idle_ok); end
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_op = 2'b00; req_x = 16'h0000; req_y = 8'h00;
    rsp_ready = 1'b0; alu_outbus = 8'h00; alu_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    #2 reset = 1'b1;
    step();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_div_by_zero();
    test_timeout();
    test_end_priority();
    test_backpressure();
    test_stray_end();
    test_reset_mid_load();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
